// File: rtl/rr_mux_arb_if.sv
// rtl/rr_mux_arb_if.sv - handshake bundle between input channels, arbiter and downstream sink
//
// Purpose: carries the packed per-channel request side and the single output slot side.
// Ports (signals):
//   in_data   CHANNELS*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel request
//   in_ready  CHANNELS        per-channel accept (one-hot or zero)
//   out_data  WIDTH           registered selected word
//   out_valid 1               output slot holds a word
//   out_ready 1               downstream accept
//   out_sel   SELW            channel index of out_data
// Modports: master = channel/sink side, slave = arbiter side.
interface rr_mux_arb_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SELW-1:0]           out_sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - round-robin / fixed-priority N:1 mux into a single output register slot
//
// Purpose: picks one requesting channel per cycle and loads its word into a one-entry
// output slot. The slot can drain and refill in the same cycle, so a continuously
// ready sink sees one word per cycle.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   mode   in   0 = round-robin from ptr, 1 = fixed priority (lowest index wins)
//   bus    slave modport of rr_mux_arb_if (channel requests, output slot)
module rr_mux_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  rr_mux_arb_if.slave    bus
);

  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  sel_q;
  logic             valid_q;
  logic [SELW-1:0]  ptr_q;

  logic             can_load;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;
  int               start;

  // Slot accepts a new word when empty or when its current word leaves this cycle.
  assign can_load = !valid_q || bus.out_ready;

  // Search order is start..CHANNELS-1 then 0..start-1. The wrapped half is scanned
  // first and the unwrapped half second so the later (higher-priority) hit wins;
  // each pass runs downward so the lowest index within that pass is kept.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    start     = mode ? 0 : int'(ptr_q);
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (bus.in_valid[j] && (j < start)) begin
        grant_any = 1'b1;
        grant_idx = SELW'(j);
      end
    end
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (bus.in_valid[j] && (j >= start)) begin
        grant_any = 1'b1;
        grant_idx = SELW'(j);
      end
    end
  end

  // Reset gates the grant so nothing is accepted while the slot is being cleared.
  assign xfer = can_load && grant_any && rst_n;

  always_comb begin
    bus.in_ready = '0;
    grant_data   = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (grant_idx == SELW'(j)) begin
        bus.in_ready[j] = xfer;
        grant_data      = bus.in_data[j*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (xfer) begin
      data_q  <= grant_data;
      sel_q   <= grant_idx;
      valid_q <= 1'b1;
      // Pointer advances on every transfer, even in fixed-priority mode, so that
      // switching back to round-robin resumes after the last served channel.
      ptr_q   <= (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule
